// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide engine for MULT, MULTU, DIV and DIVU.
// One shift-add or restoring-subtract step per clock, then a sign-fix cycle.
// Results land in HI/LO with a one-cycle done pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo,
  output logic             oDivZero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Magnitude of a value; only signed operations strip the sign.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                               input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  // Conditional two's-complement negate, single width.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? WIDTH'(-v) : v;
  endfunction

  // Conditional two's-complement negate, full product width.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (2*WIDTH)'(-v) : v;
  endfunction

  logic [1:0]       state;
  logic [1:0]       op_q;       // bit1: divide, bit0: signed
  logic [WIDTH-1:0] opd_r;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] a_sav;      // dividend as captured, returned on divide by zero
  logic [WIDTH-1:0] rem_r;      // product high half or partial remainder
  logic [WIDTH-1:0] lo_r;       // multiplier/product low half or dividend/quotient
  logic             neg_q;      // product / quotient sign
  logic             neg_r;      // remainder sign (dividend sign)
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             sgn_in;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] lo_nxt;

  assign accept = iStart && ((state == S_IDLE) || (state == S_DONE));
  assign sgn_in = iOp[0];
  assign oBusy  = (state == S_RUN) || (state == S_FIX);
  assign oDone  = (state == S_DONE);

  // One iteration of shift-add (multiply) or restoring subtract (divide).
  always_comb begin
    rem_nxt   = rem_r;
    lo_nxt    = lo_r;
    mul_sum   = {1'b0, rem_r} + (lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    div_shift = {rem_r, lo_r[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd_r};
    if (op_q[1]) begin
      rem_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_nxt  = {lo_r[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      rem_nxt = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], lo_r[WIDTH-1:1]};
    end
  end

  // State sequencing and step counter.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          cnt   <= '0;
          state <= accept ? S_RUN : S_IDLE;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX:   state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture on accept, then one datapath step per RUN cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      op_q  <= '0;
      opd_r <= '0;
      a_sav <= '0;
      rem_r <= '0;
      lo_r  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      op_q  <= iOp;
      a_sav <= iA;
      rem_r <= '0;
      opd_r <= iOp[1] ? abs_val(iB, sgn_in) : abs_val(iA, sgn_in);
      lo_r  <= iOp[1] ? abs_val(iA, sgn_in) : abs_val(iB, sgn_in);
      neg_q <= sgn_in & (iA[WIDTH-1] ^ iB[WIDTH-1]);
      neg_r <= sgn_in & iA[WIDTH-1];
    end else if (state == S_RUN) begin
      rem_r <= rem_nxt;
      lo_r  <= lo_nxt;
    end
  end

  // Sign fix and result registers, written only in the FIX cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oHi      <= '0;
      oLo      <= '0;
      oDivZero <= 1'b0;
    end else if (state == S_FIX) begin
      if (!op_q[1]) begin
        {oHi, oLo} <= neg_2w({rem_r, lo_r}, neg_q);
        oDivZero   <= 1'b0;
      end else if (opd_r == '0) begin
        oHi      <= a_sav;
        oLo      <= '1;
        oDivZero <= 1'b1;
      end else begin
        oHi      <= neg_w(rem_r, neg_r);
        oLo      <= neg_w(lo_r, neg_q);
        oDivZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, control
// scenario (ignored restart, back-to-back start, mid-run reset) and random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         iCLK;
  logic         iRST_N;
  logic         iStart;
  logic [1:0]   iOp;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         oBusy;
  logic         oDone;
  logic [W-1:0] oHi;
  logic [W-1:0] oLo;
  logic         oDivZero;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iStart   (iStart),
    .iOp      (iOp),
    .iA       (iA),
    .iB       (iB),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oHi      (oHi),
    .oLo      (oLo),
    .oDivZero (oDivZero)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    logic [63:0] ua, ub, up;
    longint      sa, sb, sp, sq, sr;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op[1] && b == 0) begin
      hi = a;
      lo = '1;
      dz = 1'b1;
    end else begin
      case (op)
        2'b00: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
        2'b01: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
        2'b10: begin lo = W'(ua / ub); hi = W'(ua % ub); end
        default: begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      endcase
    end
  endtask

  // Start one op (caller is just after a clock edge), wait for done, check all results.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit idle_after);
    logic [W-1:0] eh, el;
    logic         ed;
    int           k;
    model(op, a, b, eh, el, ed);
    iOp = op; iA = a; iB = b; iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    iA = $urandom; iB = $urandom; iOp = 2'($urandom);
    check({tag, "_busy"}, 64'(oBusy), 64'd1);
    k = 0;
    while (!oDone && k < 200) begin
      @(posedge iCLK); #1;
      k++;
    end
    check({tag, "_done_edges"}, 64'(k), 64'(W + 1));
    check({tag, "_busy_in_done"}, 64'(oBusy), 64'd0);
    check({tag, "_hi"}, 64'(oHi), 64'(eh));
    check({tag, "_lo"}, 64'(oLo), 64'(el));
    check({tag, "_dz"}, 64'(oDivZero), 64'(ed));
    if (idle_after) begin
      @(posedge iCLK); #1;
      check({tag, "_done_pulse"}, 64'(oDone), 64'd0);
      check({tag, "_hold"}, {oHi, oLo}, {eh, el});
    end
  endtask

  initial begin
    int k;
    int done_seen;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    iRST_N = 1'b0; iStart = 1'b0; iOp = '0; iA = '0; iB = '0;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_hilo", {oHi, oLo}, 64'd0);
    check("rst_dz",   64'(oDivZero), 64'd0);
    @(negedge iCLK); iRST_N = 1'b1;
    @(posedge iCLK); #1;

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("multu_max_hi_const", 64'(oHi), 64'hFFFFFFFE);
    check("multu_max_lo_const", 64'(oLo), 64'h00000001);
    run_op("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd7, 1'b1);
    check("mult_neg_lo_const", 64'(oLo), 64'hFFFFFFEB);
    run_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2, 1'b1);
    check("div_neg_hi_const", 64'(oHi), 64'hFFFFFFFF);
    run_op("div_wrap",  2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    check("div_wrap_lo_const", 64'(oLo), 64'h80000000);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0, 1'b1);
    check("divu_zero_hi_const", 64'(oHi), 64'h64);
    run_op("multu_small", 2'b00, 32'd2, 32'd3, 1'b1);
    run_op("div_zero_signed", 2'b11, 32'hFFFFFF00, 32'd0, 1'b1);
    run_op("mult_min", 2'b01, 32'h80000000, 32'h80000000, 1'b1);

    // Control scenario: restart during RUN is ignored.
    iOp = 2'b10; iA = 32'd9; iB = 32'd4; iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    repeat (4) @(posedge iCLK);
    #1;
    iOp = 2'b00; iA = 32'd100; iB = 32'd3; iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    k = 5;
    while (!oDone && k < 200) begin
      @(posedge iCLK); #1;
      k++;
    end
    check("ign_done_edges", 64'(k), 64'(W + 1));
    check("ign_lo", 64'(oLo), 64'd2);
    check("ign_hi", 64'(oHi), 64'd1);

    // Start in the DONE cycle is accepted.
    iOp = 2'b01; iA = 32'hFFFFFFFD; iB = 32'd7; iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    check("b2b_busy", 64'(oBusy), 64'd1);
    check("b2b_no_done", 64'(oDone), 64'd0);

    // Asynchronous reset in the middle of RUN.
    repeat (10) @(posedge iCLK);
    #3 iRST_N = 1'b0;
    #1;
    check("arst_busy", 64'(oBusy), 64'd0);
    check("arst_done", 64'(oDone), 64'd0);
    check("arst_hilo", {oHi, oLo}, 64'd0);
    check("arst_dz",   64'(oDivZero), 64'd0);
    @(negedge iCLK); iRST_N = 1'b1;
    done_seen = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(posedge iCLK); #1;
      if (oDone) done_seen++;
    end
    check("arst_no_done", 64'(done_seen), 64'd0);

    // Randomized operations against the model, with forced corner operands.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", rop, ra, rb, (i % 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
